// File: rtl/perfil_pkg.sv
// perfil_pkg: shared state encoding and profile codes for perfil_arbitro
package perfil_pkg;
   typedef enum logic [1:0] {IDLE, GRANT, HOLD, DONE} state_e;
   localparam logic [2:0] PERFIL_INVALID = 3'b000;
   localparam int PW_DEFAULT = 3;
endpackage

// File: rtl/perfil_rr_select.sv
// perfil_rr_select: round-robin winner search starting just above the pointer
module perfil_rr_select #(
   parameter int NUM_IF = 2,
   parameter int IW = (NUM_IF > 1) ? $clog2(NUM_IF) : 1
) (
   input  logic [NUM_IF-1:0] req_i,
   input  logic [IW-1:0]     ptr_i,
   output logic [NUM_IF-1:0] onehot_o,
   output logic [IW-1:0]     idx_o,
   output logic              any_o
);
   logic [IW-1:0] j;
   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      j        = '0;
      any_o    = |req_i;
      // scan farthest to nearest so the closest requester above the pointer wins
      for (int k = NUM_IF; k >= 1; k--) begin
         j = IW'((int'(ptr_i) + k) % NUM_IF);
         if (req_i[j]) begin
            onehot_o    = '0;
            onehot_o[j] = 1'b1;
            idx_o       = j;
         end
      end
   end
endmodule

// File: rtl/perfil_arbitro.sv
// perfil_arbitro: shares one profile-transfer path between NUM_IF requesters.
// Round-robin by default; PERFIL_ARBITRO_PRIORITY_EN selects fixed lowest-index priority.
module perfil_arbitro
   import perfil_pkg::*;
#(
   parameter int NUM_IF      = 2,
   parameter int PW          = PW_DEFAULT,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic [NUM_IF-1:0]    req_i,
   input  logic [NUM_IF*PW-1:0] perfil_in_i,
   output logic [PW-1:0]        perfil_out_o,
   output logic                 perfil_valid_o,
   output logic [NUM_IF-1:0]    grant_o,
   output logic [NUM_IF-1:0]    ack_o,
   output logic                 err_o,
   output logic                 busy_o
);
   localparam int IW = (NUM_IF > 1) ? $clog2(NUM_IF) : 1;
   localparam int CW = $clog2(HOLD_CYCLES + 1);

   state_e            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d, win_q, win_d, sel_idx;
   logic [NUM_IF-1:0] grant_q, grant_d, ack_q, ack_d, sel_oh;
   logic [PW-1:0]     perfil_q, perfil_d, slice;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              valid_q, valid_d, err_q, err_d, busy_q, busy_d, any_req;
   logic [PW-1:0]     prof_a [NUM_IF];

   for (genvar g = 0; g < NUM_IF; g++) begin : g_unpack
      assign prof_a[g] = perfil_in_i[g*PW +: PW];
   end
   assign slice = prof_a[win_q];

   // with the pointer frozen at NUM_IF-1 the search always starts at index 0
   perfil_rr_select #(.NUM_IF(NUM_IF), .IW(IW)) u_sel (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .onehot_o(sel_oh),
      .idx_o   (sel_idx),
      .any_o   (any_req)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      win_d    = win_q;
      grant_d  = grant_q;
      perfil_d = perfil_q;
      valid_d  = valid_q;
      cnt_d    = cnt_q;
      ack_d    = '0;
      err_d    = 1'b0;
      case (state_q)
         IDLE: if (any_req) begin
            state_d = GRANT;
            grant_d = sel_oh;
            win_d   = sel_idx;
         end
         GRANT: if (slice == PW'(PERFIL_INVALID)) begin
            err_d   = 1'b1;
            ack_d   = grant_q;
            state_d = DONE;
         end else begin
            perfil_d = slice;
            valid_d  = 1'b1;
            cnt_d    = CW'(HOLD_CYCLES - 1);
            state_d  = HOLD;
         end
         HOLD: if (cnt_q == '0) begin
            state_d  = DONE;
            ack_d    = grant_q;
            valid_d  = 1'b0;
            perfil_d = '0;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
         DONE: begin
            grant_d = '0;
`ifdef PERFIL_ARBITRO_PRIORITY_EN
            ptr_d   = ptr_q;
`else
            ptr_d   = win_q;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= IDLE;
         ptr_q    <= IW'(NUM_IF - 1);
         win_q    <= '0;
         grant_q  <= '0;
         perfil_q <= '0;
         valid_q  <= 1'b0;
         cnt_q    <= '0;
         ack_q    <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         win_q    <= win_d;
         grant_q  <= grant_d;
         perfil_q <= perfil_d;
         valid_q  <= valid_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   assign perfil_out_o   = perfil_q;
   assign perfil_valid_o = valid_q;
   assign grant_o        = grant_q;
   assign ack_o          = ack_q;
   assign err_o          = err_q;
   assign busy_o         = busy_q;
endmodule

// File: doc/perfil_arbitro.md
Name: perfil_arbitro

Overview:
- Sequencing controller that shares the single profile-transfer path between NUM_IF access interfaces.
- Each interface raises a request with a PW-bit profile. The block arbitrates round-robin and latches the winner's profile.
- It then presents the profile to the downstream checker for HOLD_CYCLES cycles and returns a one-cycle ack to the winner.
- Profile 000 is the codebase's "invalid/no profile" code. It is rejected with an error pulse and never forwarded.

Parameters:
- NUM_IF, 2, number of requesting interfaces (2..8).
- PW, 3, profile width in bits.
- HOLD_CYCLES, 4, cycles perfil_valid stays high per transfer (>=1).

Ports:
- clk  input  1  single system clock, rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- req  input  NUM_IF  per-interface request; held until ack.
- perfil_in  input  NUM_IF*PW  profiles packed; interface i at bits [i*PW +: PW].
- perfil_out  output  PW  latched profile of current winner; 000 when not valid.
- perfil_valid  output  1  high while perfil_out is presented.
- grant  output  NUM_IF  one-hot current winner; all zero in IDLE.
- ack  output  NUM_IF  one-cycle pulse to winner at end of transaction.
- err  output  1  one-cycle pulse when winner's profile is 000.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; perfil_out=0, perfil_valid=0, grant=0, ack=0, err=0, busy=0; hold counter=0.
  - rr pointer=NUM_IF-1, so interface 0 wins first.
- All outputs are registered.
- States:
  - IDLE: if any req bit is high, select the winner and go to GRANT. The winner is the first set bit searching from pointer+1 upward, wrapping modulo NUM_IF. grant registers the winner.
  - GRANT (1 cycle): capture the winner's perfil_in slice.
    - If nonzero: perfil_out=slice, perfil_valid=1, counter=HOLD_CYCLES-1, go to HOLD.
    - If zero: err=1 and ack[winner]=1 for the next cycle, go to DONE.
  - HOLD: perfil_valid stays 1 and perfil_out is stable. Decrement the counter; when the counter reaches 0, go to DONE and issue ack[winner]=1 and clear perfil_valid/perfil_out at the same edge.
  - DONE (1 cycle): ack/err are high for exactly this cycle. Set pointer=winner index, clear grant, go to IDLE.
- Latency: req sampled high at edge 0 leads to:
  - grant at edge 1;
  - perfil_valid at edge 2 for exactly HOLD_CYCLES cycles;
  - ack at edge 2+HOLD_CYCLES.
- Minimum back-to-back spacing is HOLD_CYCLES+3 cycles.
- Boundary conditions:
  - Request dropped after grant: ignored. The transaction completes using the profile captured in GRANT, and ack is still pulsed.
  - perfil_in changing during HOLD: no effect on perfil_out.
  - Requester still high after ack: treated as a new request and re-arbitrated in IDLE. Round-robin gives the other interfaces priority.
  - Simultaneous requests: only one grant. The rest wait without loss.
  - Requests from unselected interfaces are never acked.
  - Reset mid-transaction: immediate return to reset values. No ack or err is produced for the aborted transfer.
  - Pointer arithmetic wraps: NUM_IF-1 + 1 goes to 0.

Optional Feature:
- Macro: PERFIL_ARBITRO_PRIORITY_EN.
- When defined: fixed priority (lowest index wins); the pointer is unused and is held at reset value.
- When undefined: round-robin as above.
- All other timing is identical in both modes.

Decomposition:
- Shared package perfil_pkg holds:
  - state encoding (IDLE, GRANT, HOLD, DONE);
  - PERFIL_INVALID = 3'b000;
  - default PW = 3.
- One natural sub-module: perfil_rr_select. It is combinational and takes req and pointer, producing the one-hot winner and its index plus an any_req flag.
- The FSM, counter and registers stay in the top.

Test Plan:
- Single request: req=01, perfil_in[2:0]=101, HOLD_CYCLES=4 -> grant=01 at edge 1; perfil_out=101 with perfil_valid high for edges 2..5; ack=01 pulses at edge 6; busy low afterwards.
- Invalid profile: req=10, perfil_in[5:3]=000 -> grant=10, no perfil_valid, err=1 and ack=10 for one cycle, back to IDLE.
- Contention: req=11 held continuously, profiles 011/110 -> grants alternate 01,10,01,... with perfil_out alternating 011,110. With PERFIL_ARBITRO_PRIORITY_EN defined, grant is always 01.
- Request drop and input change: req=01 with profile 111, deassert req and change profile to 010 during HOLD -> perfil_out stays 111 for 4 cycles and ack=01 still pulses.
- Reset mid-HOLD: assert reset_n=0 during the 2nd cycle of perfil_valid -> all outputs 0 immediately, no ack. After release, req=11 is granted to interface 0 first.
